adat_frame_controller: RTL and testbench

ADAT_FRAME_CONTROLLER -- requirements
Module: adat_frame_controller

---
 rtl/adat_frame_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_adat_frame_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_controller.sv
// ADAT frame controller: hunts for the sync run, unpacks user bits and eight 24-bit channels,
// and tracks lock. Define ADAT_FRAME_ERR_COUNT_EN to build the saturating frame-error counter.
module adat_frame_controller #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned SYNC_ZEROS  = 10
) (
    input  logic        clk_x4_i,
    input  logic        rst_i,
    input  logic        bit_tick_ni,
    input  logic        data_i,
    input  logic        valid_i,
    input  logic        sync_i,
    output logic [23:0] sample_o,
    output logic [2:0]  chan_o,
    output logic        sample_valid_o,
    output logic [3:0]  user_o,
    output logic        frame_o,
    output logic        locked_o,
    output logic [7:0]  err_count_o
);

    localparam logic [7:0] SyncLen = 8'(SYNC_ZEROS);
    localparam logic [3:0] LockLen = 4'(LOCK_FRAMES);

    typedef enum logic [2:0] {StIdle, StHunt, StSync, StGroup, StError} state_e;

    state_e      state_q, state_d;
    logic [7:0]  zcnt_q, zcnt_d;
    logic [2:0]  pos_q, pos_d;
    logic [5:0]  grp_q, grp_d;
    logic [2:0]  nib_q, nib_d;
    logic [2:0]  chan_q, chan_d;
    logic [23:0] shreg_q, shreg_d;
    logic [3:0]  user_pend_q, user_pend_d;
    logic [3:0]  good_q, good_d;
    logic [23:0] sample_q, sample_d;
    logic [2:0]  chan_out_q, chan_out_d;
    logic        sv_q, sv_d;
    logic [3:0]  user_q, user_d;
    logic        frame_q, frame_d;
    logic        locked_q, locked_d;
    logic        err_inc;

    logic        bit_ev;
    logic        fault;
    logic        drop;
    logic [23:0] shifted;

    assign bit_ev  = ~bit_tick_ni;
    assign shifted = {shreg_q[22:0], data_i};

    always_comb begin
        state_d     = state_q;
        zcnt_d      = zcnt_q;
        pos_d       = pos_q;
        grp_d       = grp_q;
        nib_d       = nib_q;
        chan_d      = chan_q;
        shreg_d     = shreg_q;
        user_pend_d = user_pend_q;
        good_d      = good_q;
        sample_d    = sample_q;
        chan_out_d  = chan_out_q;
        sv_d        = 1'b0;
        user_d      = user_q;
        frame_d     = 1'b0;
        locked_d    = locked_q;
        err_inc     = 1'b0;
        fault       = 1'b0;
        drop        = 1'b0;

        if (bit_ev) begin
            if (state_q != StIdle && !valid_i) begin
                drop    = 1'b1;
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (valid_i) begin
                            state_d = StHunt;
                            zcnt_d  = '0;
                        end
                    end
                    StHunt: begin
                        if (!data_i) begin
                            zcnt_d = (zcnt_q == 8'hFF) ? zcnt_q : zcnt_q + 8'd1;
                        end else begin
                            zcnt_d = '0;
                            if (zcnt_q == SyncLen && sync_i) begin
                                state_d = StGroup;
                                grp_d   = '0;
                                pos_d   = 3'd1;
                                nib_d   = '0;
                                chan_d  = '0;
                            end
                        end
                    end
                    StSync: begin
                        if (!data_i) begin
                            if (zcnt_q == SyncLen) fault = 1'b1;
                            else                   zcnt_d = zcnt_q + 8'd1;
                        end else if (zcnt_q == SyncLen) begin
                            state_d = StGroup;
                            grp_d   = '0;
                            pos_d   = 3'd1;
                            nib_d   = '0;
                            chan_d  = '0;
                        end else begin
                            fault = 1'b1;
                        end
                    end
                    StGroup: begin
                        if (pos_q == 3'd0) begin
                            if (!data_i) fault = 1'b1;
                            else         pos_d = 3'd1;
                        end else begin
                            shreg_d = shifted;
                            if (pos_q == 3'd4) begin
                                pos_d = 3'd0;
                                if (grp_q == 6'd0) begin
                                    user_pend_d = shifted[3:0];
                                end else if (nib_q == 3'd5) begin
                                    nib_d      = '0;
                                    sample_d   = shifted;
                                    chan_out_d = chan_q;
                                    sv_d       = 1'b1;
                                    chan_d     = chan_q + 3'd1;
                                end else begin
                                    nib_d = nib_q + 3'd1;
                                end
                                if (grp_q == 6'd48) begin
                                    state_d  = StSync;
                                    zcnt_d   = '0;
                                    frame_d  = 1'b1;
                                    user_d   = user_pend_q;
                                    good_d   = (good_q < LockLen) ? good_q + 4'd1 : good_q;
                                    locked_d = (good_d == LockLen);
                                end else begin
                                    grp_d = grp_q + 6'd1;
                                end
                            end else begin
                                pos_d = pos_q + 3'd1;
                            end
                        end
                    end
                    StError: begin
                        state_d = StHunt;
                        zcnt_d  = '0;
                    end
                    default: state_d = StIdle;
                endcase
            end

            if (fault) state_d = StError;
            if (fault || drop) begin
                good_d   = '0;
                locked_d = 1'b0;
                err_inc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_x4_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            zcnt_q      <= '0;
            pos_q       <= '0;
            grp_q       <= '0;
            nib_q       <= '0;
            chan_q      <= '0;
            shreg_q     <= '0;
            user_pend_q <= '0;
            good_q      <= '0;
            sample_q    <= '0;
            chan_out_q  <= '0;
            sv_q        <= 1'b0;
            user_q      <= '0;
            frame_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            zcnt_q      <= zcnt_d;
            pos_q       <= pos_d;
            grp_q       <= grp_d;
            nib_q       <= nib_d;
            chan_q      <= chan_d;
            shreg_q     <= shreg_d;
            user_pend_q <= user_pend_d;
            good_q      <= good_d;
            sample_q    <= sample_d;
            chan_out_q  <= chan_out_d;
            sv_q        <= sv_d;
            user_q      <= user_d;
            frame_q     <= frame_d;
            locked_q    <= locked_d;
        end
    end

`ifdef ADAT_FRAME_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk_x4_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count_o = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_count_o    = '0;
`endif

    assign sample_o       = sample_q;
    assign chan_o         = chan_out_q;
    assign sample_valid_o = sv_q;
    assign user_o         = user_q;
    assign frame_o        = frame_q;
    assign locked_o       = locked_q;

endmodule

// File: tb/tb_adat_frame_controller.sv
// Scoreboard bench for adat_frame_controller: frames are serialised bit by bit, expected
// samples and frame user values are queued up front and popped by an output monitor.
module tb_adat_frame_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_n = 1'b1;
    logic        data = 1'b0;
    logic        valid = 1'b0;
    logic        sync = 1'b0;
    logic [23:0] sample;
    logic [2:0]  chan;
    logic        sample_valid;
    logic [3:0]  user;
    logic        frame;
    logic        locked;
    logic [7:0]  err_count;

    typedef struct packed {
        logic [2:0]  ch;
        logic [23:0] s;
    } samp_t;

    samp_t       sq[$];
    logic [3:0]  fq[$];
    int          total = 0;
    int          bad = 0;
    int          zrun = 0;
    int          err_model = 0;
    logic [23:0] ch_val[8];
    logic [3:0]  user_val;

    adat_frame_controller #(
        .LOCK_FRAMES(2),
        .SYNC_ZEROS (10)
    ) dut (
        .clk_x4_i      (clk),
        .rst_i         (rst),
        .bit_tick_ni   (tick_n),
        .data_i        (data),
        .valid_i       (valid),
        .sync_i        (sync),
        .sample_o      (sample),
        .chan_o        (chan),
        .sample_valid_o(sample_valid),
        .user_o        (user),
        .frame_o       (frame),
        .locked_o      (locked),
        .err_count_o   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int err_exp();
`ifdef ADAT_FRAME_ERR_COUNT_EN
        return err_model;
`else
        return 0;
`endif
    endfunction

    function automatic void add_err();
        if (err_model < 255) err_model++;
    endfunction

    always @(negedge clk) begin : monitor
        samp_t e;
        if (!rst) begin
            if (sample_valid) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample: got chan=%0d sample=%06h expected none",
                             chan, sample);
                end else begin
                    e = sq.pop_front();
                    check("sample_chan", 32'(chan), 32'(e.ch));
                    check("sample_data", 32'(sample), 32'(e.s));
                end
            end
            if (frame) begin
                if (fq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got user=%0h expected none", user);
                end else begin
                    check("frame_user", 32'(user), 32'(fq.pop_front()));
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        data   = b;
        sync   = (zrun >= 8);
        tick_n = 1'b0;
        @(negedge clk);
        tick_n = 1'b1;
        repeat (3) @(negedge clk);
        zrun = b ? 0 : zrun + 1;
    endtask

    // Group indices of 99 mean "none"; bad_grp sends a 0 separator, stop_grp truncates the
    // frame, drop_grp lowers valid from that group on.
    task automatic send_frame(input int nz, input bit lead, input int bad_grp, input int stop_grp,
                              input int drop_grp, input bit good);
        int          lim;
        samp_t       e;
        logic [23:0] w;
        logic [3:0]  nib;
        lim = bad_grp;
        if (stop_grp < lim) lim = stop_grp;
        if (drop_grp < lim) lim = drop_grp;
        if (good) begin
            for (int c = 0; c < 8; c++) begin
                if (6 * c + 6 < lim) begin
                    e.ch = 3'(c);
                    e.s  = ch_val[c];
                    sq.push_back(e);
                end
            end
            if (lim == 99) fq.push_back(user_val);
        end
        if (lead) send_bit(1'b1);
        repeat (nz) send_bit(1'b0);
        for (int g = 0; g < 49; g++) begin
            if (g == stop_grp) return;
            if (g == drop_grp) begin
                valid = 1'b0;
                add_err();
            end
            if (g == bad_grp) begin
                send_bit(1'b0);
                add_err();
                repeat (3) send_bit(1'b1);
                return;
            end
            send_bit(1'b1);
            if (g == 0) begin
                nib = user_val;
            end else begin
                w   = ch_val[(g - 1) / 6];
                nib = 4'(w >> (20 - 4 * ((g - 1) % 6)));
            end
            for (int b = 3; b >= 0; b--) send_bit(nib[b]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sample"}, 32'(sample), 32'h0);
        check({tag, "_chan"}, 32'(chan), 32'h0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_user"}, 32'(user), 32'h0);
        check({tag, "_frame"}, 32'(frame), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_err"}, 32'(err_count), 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        rst       = 1'b0;
        err_model = 0;
    endtask

    task automatic set_a();
        user_val = 4'hA;
        for (int c = 0; c < 8; c++) ch_val[c] = 24'(c + 1);
    endtask

    task automatic set_b();
        user_val = 4'h5;
        for (int c = 0; c < 8; c++) ch_val[c] = (c == 3) ? 24'hFFFFFF : 24'h800000;
    endtask

    initial begin
        set_a();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst   = 1'b0;
        valid = 1'b1;
        repeat (3) send_bit(1'b1);

        // Two clean frames lock the stream
        send_frame(10, 1'b1, 99, 99, 99, 1'b1);
        check("lock_after_frame1", 32'(locked), 32'h0);
        send_frame(10, 1'b0, 99, 99, 99, 1'b1);
        check("lock_after_frame2", 32'(locked), 32'h1);
        check("err_clean", 32'(err_count), 32'(err_exp()));

        set_b();
        send_frame(10, 1'b0, 99, 99, 99, 1'b1);
        check("lock_pattern_b", 32'(locked), 32'h1);

        // Bad separator in group 20 of a locked stream, then relock
        set_a();
        send_frame(10, 1'b0, 20, 99, 99, 1'b1);
        check("lock_after_sep_err", 32'(locked), 32'h0);
        check("err_after_sep_err", 32'(err_count), 32'(err_exp()));
        send_frame(10, 1'b1, 99, 99, 99, 1'b1);
        check("relock_frame1", 32'(locked), 32'h0);
        send_frame(10, 1'b0, 99, 99, 99, 1'b1);
        check("relock_frame2", 32'(locked), 32'h1);

        // Sync runs of 9 and 11 zeros are ignored without error
        pulse_reset();
        repeat (3) send_bit(1'b1);
        send_frame(9, 1'b1, 99, 99, 99, 1'b0);
        check("lock_sync9", 32'(locked), 32'h0);
        check("err_sync9", 32'(err_count), 32'h0);
        send_frame(11, 1'b1, 99, 99, 99, 1'b0);
        check("lock_sync11", 32'(locked), 32'h0);
        check("err_sync11", 32'(err_count), 32'h0);
        send_frame(10, 1'b1, 99, 99, 99, 1'b1);
        check("lock_sync10_f1", 32'(locked), 32'h0);
        send_frame(10, 1'b0, 99, 99, 99, 1'b1);
        check("lock_sync10_f2", 32'(locked), 32'h1);

        // valid drops in the middle of channel 5
        send_frame(10, 1'b0, 99, 99, 33, 1'b1);
        check("lock_after_drop", 32'(locked), 32'h0);
        check("err_after_drop", 32'(err_count), 32'(err_exp()));
        check("samples_after_drop", 32'(sq.size()), 32'h0);
        valid = 1'b1;
        repeat (3) send_bit(1'b1);

        // 300 error frames drive the counter into saturation
        repeat (300) send_frame(10, 1'b1, 1, 99, 99, 1'b1);
        check("err_saturated", 32'(err_count), 32'(err_exp()));
        check("lock_after_errors", 32'(locked), 32'h0);

        // Reset in mid-frame: channel 0 completes, the rest is discarded silently
        send_frame(10, 1'b1, 99, 10, 99, 1'b1);
        pulse_reset();
        repeat (3) send_bit(1'b1);
        send_frame(10, 1'b1, 99, 99, 99, 1'b1);
        send_frame(10, 1'b0, 99, 99, 99, 1'b1);
        check("lock_after_midreset", 32'(locked), 32'h1);
        check("user_after_midreset", 32'(user), 32'hA);

        repeat (10) @(negedge clk);
        check("sample_queue_drained", 32'(sq.size()), 32'h0);
        check("frame_queue_drained", 32'(fq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
